tt_ffs_rr_arb: RTL and testbench
================================

# tt_ffs_rr_arb

Registered, mode-selectable find-first-set arbiter with integrated data muxing and encode. It is the successor to the combinational find-first-set tree and adds a round-robin priority pointer, a runtime priority mode, and a valid/ready output stage. It sits in the VPU between multiple requesters (lanes/queues) and a single downstream consumer. Each accepted cycle, it picks one requester and captures its data, one-hot grant and encoded index into an output register.

## Interface
- WIDTH, 8: number of requesters; power of two, ≥ 2.
- SIZE, $clog2(WIDTH): index width.
- DATA_WIDTH, 4: per-requester data width.

- i_clk  in  1  clock, all state on rising edge.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_mode  in  2  priority mode: 0 = fixed L2H (lsb wins), 1 = fixed H2L (msb wins), 2/3 = round-robin.
- i_flush  in  1  drop held output, reset pointer.
- i_req  in  WIDTH  request vector.
- i_data  in  WIDTH×DATA_WIDTH  per-requester data, packed [WIDTH-1:0][DATA_WIDTH-1:0].
- o_gnt  out  WIDTH  combinational one-hot: requester captured this cycle.
- o_vld  out  1  output register holds a pick.
- i_rdy  in  1  consumer accepts the output.
- o_data  out  DATA_WIDTH  data of the picked requester.
- o_gnt_oh  out  WIDTH  registered one-hot of the picked requester.
- o_enc  out  SIZE  registered index of the picked requester.
- o_ptr  out  SIZE  current round-robin pointer (highest-priority index).

## Operation
- in_ready = !o_vld | i_rdy. capture = in_ready & |i_req & !i_flush.
- Selection is combinational on i_req, i_mode and ptr:
  - Mode 0: lowest set index.
  - Mode 1: highest set index.
  - RR mode: first set index scanning upward from ptr, wrapping WIDTH-1 → 0. Implement as rotate-right by ptr, L2H find-first-set, then add ptr mod 2^SIZE.
- o_gnt = one-hot(sel) when capture, else 0. Requesters drop or advance on o_gnt.
- On capture, the register loads o_data = i_data[sel], o_gnt_oh = one-hot(sel), o_enc = sel, and o_vld is set to 1.
- When o_vld & i_rdy & !capture, o_vld is cleared to 0. Data, gnt and enc registers hold their value (don't-care for consumers).
- Pointer updates only on capture in RR mode: ptr = (sel + 1) mod WIDTH, wrapping 7 → 0 for WIDTH = 8. In fixed modes, ptr holds.
- A mode change takes effect on the same cycle's selection. ptr is retained across mode changes.
- Flush has priority over capture and over accept. Next cycle: o_vld = 0, ptr = 0. o_gnt = 0 in the flush cycle.
- No request (i_req = 0): no capture, o_gnt = 0, ptr holds.

## Timing
- Reset (async assert, synchronous release on i_clk): o_vld = 0, o_data = 0, o_gnt_oh = 0, o_enc = 0, ptr = 0. o_gnt is 0 while in reset.
- Latency: request → o_vld is 1 cycle. Throughput is 1 pick/cycle while i_rdy = 1.
- Backpressure (o_vld & !i_rdy):
  - o_gnt = 0.
  - Output registers are stable.
  - ptr holds.
  - Requests are not consumed.
- Simultaneous accept and new capture: the register reloads with no bubble.
- Reset mid-operation: the pending output is discarded immediately and no grant is issued.
- Combinational paths:
  - i_req/i_mode/i_rdy/i_flush → o_gnt.
  - i_rdy → o_vld does not exist; o_vld is a register output.

## Test plan
- Fixed L2H, i_mode = 0, i_req = 8'b1010_0100, i_rdy = 1 → o_gnt = 8'h04 same cycle. Next cycle: o_vld = 1, o_enc = 2, o_data = i_data[2], ptr = 0.
- Fixed H2L, same request → o_gnt = 8'h80. Next cycle: o_enc = 7, o_gnt_oh = 8'h80.
- Round-robin fairness, i_mode = 2, i_req = 8'hFF held, i_rdy = 1 for 10 cycles → o_enc sequence 0,1,…,7,0,1 and ptr sequence 1,2,…,7,0,1,2.
- Wrap-around: ptr = 7, i_req = 8'b0100_0001 → picks 0, ptr becomes 1. Next pick with the same request → 6, ptr becomes 7.
- Backpressure: o_vld = 1 and i_rdy = 0 for 3 cycles with new requests → o_gnt = 0 and o_enc/o_data/ptr unchanged. i_rdy = 1 → accept and capture in the same cycle, o_vld stays 1.
- Flush/reset: i_flush with o_vld = 1 and pending requests → o_gnt = 0, next cycle o_vld = 0, ptr = 0. Asserting i_reset_n = 0 mid-stream → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tt_ffs_rr_arb_if.sv
// Request/grant/output bundle between requesters, the find-first-set arbiter and
// the downstream consumer.
interface tt_ffs_rr_arb_if #(
    parameter int WIDTH      = 8,
    parameter int DATA_WIDTH = 4,
    parameter int SIZE       = $clog2(WIDTH)
);
    logic [1:0]                        i_mode;
    logic                              i_flush;
    logic [WIDTH-1:0]                  i_req;
    logic [WIDTH-1:0][DATA_WIDTH-1:0]  i_data;
    logic [WIDTH-1:0]                  o_gnt;
    logic                              o_vld;
    logic                              i_rdy;
    logic [DATA_WIDTH-1:0]             o_data;
    logic [WIDTH-1:0]                  o_gnt_oh;
    logic [SIZE-1:0]                   o_enc;
    logic [SIZE-1:0]                   o_ptr;

    modport master (
        output i_mode, i_flush, i_req, i_data, i_rdy,
        input  o_gnt, o_vld, o_data, o_gnt_oh, o_enc, o_ptr
    );

    modport slave (
        input  i_mode, i_flush, i_req, i_data, i_rdy,
        output o_gnt, o_vld, o_data, o_gnt_oh, o_enc, o_ptr
    );
endinterface

// File: rtl/tt_ffs_rr_arb.sv
// Registered find-first-set arbiter: fixed L2H, fixed H2L or round-robin priority,
// with the winner's data, one-hot grant and index held in a valid/ready output stage.
module tt_ffs_rr_arb #(
    parameter int WIDTH      = 8,
    parameter int SIZE       = $clog2(WIDTH),
    parameter int DATA_WIDTH = 4
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    tt_ffs_rr_arb_if.slave bus
);

    function automatic logic [SIZE-1:0] ffs_lo(input logic [WIDTH-1:0] vec);
        logic [SIZE-1:0] idx;
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = SIZE'(i);
        end
        return idx;
    endfunction

    function automatic logic [SIZE-1:0] ffs_hi(input logic [WIDTH-1:0] vec);
        logic [SIZE-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) idx = SIZE'(i);
        end
        return idx;
    endfunction

    // Rotating through a doubled copy keeps the wrap free of a variable-width mask.
    function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] vec,
                                                   input logic [SIZE-1:0]  amt);
        logic [2*WIDTH-1:0] dbl;
        dbl = {vec, vec} >> amt;
        return dbl[WIDTH-1:0];
    endfunction

    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic [WIDTH-1:0]      gnt_oh_p1;
    logic [SIZE-1:0]       enc_p1;
    logic [SIZE-1:0]       ptr_p1;

    logic                  in_ready_p0;
    logic                  capture_p0;
    logic                  rr_mode_p0;
    logic [SIZE-1:0]       sel_p0;
    logic [WIDTH-1:0]      sel_oh_p0;

    // Stage p0: combinational selection and grant
    always_comb begin
        rr_mode_p0  = bus.i_mode[1];
        in_ready_p0 = !vld_p1 || bus.i_rdy;
        capture_p0  = i_reset_n && in_ready_p0 && (|bus.i_req) && !bus.i_flush;
        case (bus.i_mode)
            2'd0:    sel_p0 = ffs_lo(bus.i_req);
            2'd1:    sel_p0 = ffs_hi(bus.i_req);
            default: sel_p0 = ffs_lo(rot_right(bus.i_req, ptr_p1)) + ptr_p1;
        endcase
        sel_oh_p0 = WIDTH'(1) << sel_p0;
    end

    assign bus.o_gnt = capture_p0 ? sel_oh_p0 : '0;

    // Stage p1: output register and round-robin pointer
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vld_p1    <= 1'b0;
            data_p1   <= '0;
            gnt_oh_p1 <= '0;
            enc_p1    <= '0;
            ptr_p1    <= '0;
        end else if (bus.i_flush) begin
            vld_p1 <= 1'b0;
            ptr_p1 <= '0;
        end else if (capture_p0) begin
            vld_p1    <= 1'b1;
            data_p1   <= bus.i_data[sel_p0];
            gnt_oh_p1 <= sel_oh_p0;
            enc_p1    <= sel_p0;
            if (rr_mode_p0) ptr_p1 <= sel_p0 + SIZE'(1);
        end else if (vld_p1 && bus.i_rdy) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.o_vld    = vld_p1;
    assign bus.o_data   = data_p1;
    assign bus.o_gnt_oh = gnt_oh_p1;
    assign bus.o_enc    = enc_p1;
    assign bus.o_ptr    = ptr_p1;

endmodule

// File: tb/tb_tt_ffs_rr_arb.sv
// Directed and randomized bench for tt_ffs_rr_arb against a scan-based priority model.
module tb_tt_ffs_rr_arb;
    localparam int WIDTH      = 8;
    localparam int DATA_WIDTH = 4;
    localparam int SIZE       = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tt_ffs_rr_arb_if #(.WIDTH(WIDTH), .DATA_WIDTH(DATA_WIDTH), .SIZE(SIZE)) bus ();

    tt_ffs_rr_arb #(.WIDTH(WIDTH), .SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: what the output stage should hold
    bit m_vld;
    int m_data, m_oh, m_enc, m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int req, input int mode, input int ptr);
        int res;
        res = -1;
        if (mode == 0) begin
            for (int k = 0; k < WIDTH; k++) if (res < 0 && req[k]) res = k;
        end else if (mode == 1) begin
            for (int k = WIDTH - 1; k >= 0; k--) if (res < 0 && req[k]) res = k;
        end else begin
            for (int k = 0; k < WIDTH; k++) begin
                int idx;
                idx = (ptr + k) % WIDTH;
                if (res < 0 && req[idx]) res = idx;
            end
        end
        return res;
    endfunction

    task automatic model_reset();
        m_vld = 0; m_data = 0; m_oh = 0; m_enc = 0; m_ptr = 0;
    endtask

    task automatic drive(input int mode, input int req, input bit rdy, input bit flush);
        bus.i_mode  = 2'(mode);
        bus.i_req   = 8'(req);
        bus.i_rdy   = rdy;
        bus.i_flush = flush;
        for (int i = 0; i < WIDTH; i++) bus.i_data[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic check_outputs();
        chk("o_vld", 32'(bus.o_vld), 32'(m_vld));
        chk("o_enc", 32'(bus.o_enc), m_enc);
        chk("o_data", 32'(bus.o_data), m_data);
        chk("o_gnt_oh", 32'(bus.o_gnt_oh), m_oh);
        chk("o_ptr", 32'(bus.o_ptr), m_ptr);
    endtask

    // Inputs are applied at posedge+1; check grant, clock once, check registers.
    task automatic cycle();
        int req, sel, cap_data;
        bit in_ready, cap;
        #1;
        req      = int'(bus.i_req);
        in_ready = !m_vld || bus.i_rdy;
        cap      = in_ready && (req != 0) && !bus.i_flush;
        sel      = pick(req, int'(bus.i_mode), m_ptr);
        cap_data = cap ? int'(bus.i_data[sel]) : 0;
        chk("o_gnt", 32'(bus.o_gnt), cap ? (1 << sel) : 0);
        @(posedge clk);
        #1;
        if (bus.i_flush) begin
            m_vld = 0;
            m_ptr = 0;
        end else if (cap) begin
            m_vld  = 1;
            m_data = cap_data;
            m_oh   = 1 << sel;
            m_enc  = sel;
            if (bus.i_mode >= 2) m_ptr = (sel + 1) % WIDTH;
        end else if (m_vld && bus.i_rdy) begin
            m_vld = 0;
        end
        check_outputs();
    endtask

    initial begin
        model_reset();
        drive(0, 8'hFF, 1, 0);
        #12;
        chk("rst_gnt", 32'(bus.o_gnt), 0);
        check_outputs();
        bus.i_req = '0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fixed L2H
        drive(0, 8'hA4, 1, 0);
        cycle();
        chk("l2h_enc", 32'(bus.o_enc), 2);
        chk("l2h_ptr", 32'(bus.o_ptr), 0);

        // Fixed H2L
        drive(1, 8'hA4, 1, 0);
        cycle();
        chk("h2l_enc", 32'(bus.o_enc), 7);
        chk("h2l_oh", 32'(bus.o_gnt_oh), 8'h80);

        drive(0, 0, 1, 0);
        cycle();

        // Round-robin fairness
        for (int i = 0; i < 10; i++) begin
            drive(2, 8'hFF, 1, 0);
            cycle();
            chk("rr_enc", 32'(bus.o_enc), i % 8);
            chk("rr_ptr", 32'(bus.o_ptr), (i + 1) % 8);
        end

        // Wrap-around from ptr = 7
        drive(2, 8'h40, 1, 0);
        cycle();
        chk("wrap_ptr7", 32'(bus.o_ptr), 7);
        drive(3, 8'h41, 1, 0);
        cycle();
        chk("wrap_enc0", 32'(bus.o_enc), 0);
        chk("wrap_ptr1", 32'(bus.o_ptr), 1);
        drive(3, 8'h41, 1, 0);
        cycle();
        chk("wrap_enc6", 32'(bus.o_enc), 6);
        chk("wrap_ptr7b", 32'(bus.o_ptr), 7);

        // Backpressure with new requests
        for (int i = 0; i < 3; i++) begin
            drive(2, $urandom_range(1, 255), 0, 0);
            cycle();
            chk("bp_enc", 32'(bus.o_enc), 6);
        end
        drive(2, 8'h0C, 1, 0);
        cycle();
        chk("bp_accept_vld", 32'(bus.o_vld), 1);
        chk("bp_accept_enc", 32'(bus.o_enc), 2);

        // Flush with pending output and requests, then flush under backpressure
        drive(2, 8'hFF, 1, 1);
        cycle();
        chk("flush_vld", 32'(bus.o_vld), 0);
        chk("flush_ptr", 32'(bus.o_ptr), 0);
        drive(2, 8'h10, 0, 0);
        cycle();
        drive(2, 8'hFF, 0, 1);
        cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3),
                  ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 255),
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0);
            cycle();
        end

        // Asynchronous reset mid-stream
        drive(2, 8'hFF, 0, 0);
        cycle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_gnt", 32'(bus.o_gnt), 0);
        check_outputs();
        @(posedge clk);
        #1;
        bus.i_req = '0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 50; i++) begin
            drive($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 1), 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
